key_debounce_multi: RTL and testbench

//   Parametrised N-channel push-button front end: synchronises, debounces and edge-detects raw active-low keys.
//   Per key: debounced level, press/release pulses, one-shot long-press pulse.

---
 rtl/key_debounce_multi_pkg.sv | 22 ++
 rtl/key_debounce_multi_if.sv | 32 +++
 rtl/key_debounce_multi_chan.sv | 177 +++++++++++++++++
 rtl/key_debounce_multi.sv | 46 ++++
 tb/tb_key_debounce_multi.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/key_debounce_multi_pkg.sv
// key_pkg: channel state encoding, default 50 MHz timing constants and the
// counter-width helper shared by key_debounce_multi and its channel module.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } key_st_t;

  localparam int DEF_KEY_NUM       = 4;
  localparam int DEF_DB_CYCLES     = 1_000_000;
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;

  // One spare bit so a counter can also hold the value n itself.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/key_debounce_multi_if.sv
// Key bus between the board pins / control logic and key_debounce_multi.
// The slave side is the debouncer; the master side drives the raw keys.
interface key_debounce_multi_if import key_pkg::*; #(
  parameter int KEY_NUM = DEF_KEY_NUM
);

  logic [KEY_NUM-1:0] key_in;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [KEY_NUM-1:0] key_release;
  logic [KEY_NUM-1:0] key_long;
  logic               key_any;

  modport master (
    output key_in,
    input  key_state,
    input  key_press,
    input  key_release,
    input  key_long,
    input  key_any
  );

  modport slave (
    input  key_in,
    output key_state,
    output key_press,
    output key_release,
    output key_long,
    output key_any
  );

endinterface

// File: rtl/key_debounce_multi_chan.sv
// key_debounce_chan: one key channel -- 2-flop synchroniser, debounce FSM,
// press/release/long-press pulses. Auto-repeat is built only with KEY_REPEAT_EN.
module key_debounce_chan import key_pkg::*; #(
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int DB_W   = cnt_w(DB_CYCLES);
  localparam int LONG_W = cnt_w(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_DONE = LONG_W'(LONG_CYCLES);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_PRESS = PRESS_DB;
  localparam logic [1:0] ST_HELD  = HELD;
  localparam logic [1:0] ST_REL   = REL_DB;

  if (DB_CYCLES < 1 || LONG_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("key_debounce_chan: all cycle parameters must be at least 1");
  end

  logic              sync1_q, sync2_q;
  logic [1:0]        st_q, st_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic [LONG_W-1:0] long_cnt_q, long_cnt_d;
  logic              state_q, state_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;
  logic              s;

`ifdef KEY_REPEAT_EN
  localparam int REP_W = cnt_w(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
`endif

  // Key is active-low on the pin; the synchroniser idles at 1 (released).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;

  always_comb begin
    st_d       = st_q;
    db_cnt_d   = db_cnt_q;
    long_cnt_d = long_cnt_q;
    state_d    = state_q;
    press_d    = 1'b0;
    rel_d      = 1'b0;
    long_d     = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    case (st_q)
      ST_IDLE: begin
        if (!s) begin
          st_d     = ST_PRESS;
          db_cnt_d = '0;
        end
      end
      ST_PRESS: begin
        if (s) begin
          st_d = ST_IDLE;
        end else if (db_cnt_q == DB_LAST) begin
          st_d       = ST_HELD;
          state_d    = 1'b1;
          press_d    = 1'b1;
          long_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      // LONG_DONE marks "long already fired"; the counter rests there.
      ST_HELD: begin
        if (long_cnt_q == LONG_LAST) begin
          long_d     = 1'b1;
          long_cnt_d = LONG_DONE;
`ifdef KEY_REPEAT_EN
          rep_cnt_d  = '0;
`endif
        end else if (long_cnt_q < LONG_LAST) begin
          long_cnt_d = long_cnt_q + 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          long_d    = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
`endif
        if (s) begin
          st_d     = ST_REL;
          db_cnt_d = '0;
        end
      end
      // Hold time keeps accruing across a release bounce, but the long
      // pulse itself can only be issued from HELD, so stop one short.
      ST_REL: begin
        if (long_cnt_q < LONG_LAST) begin
          long_cnt_d = long_cnt_q + 1'b1;
        end
        if (!s) begin
          st_d = ST_HELD;
        end else if (db_cnt_q == DB_LAST) begin
          st_d       = ST_IDLE;
          state_d    = 1'b0;
          rel_d      = 1'b1;
          long_cnt_d = '0;
`ifdef KEY_REPEAT_EN
          rep_cnt_d  = '0;
`endif
        end else begin
          db_cnt_d = db_cnt_q + 1'b1;
        end
      end
      default: begin
        st_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q       <= ST_IDLE;
      db_cnt_q   <= '0;
      long_cnt_q <= '0;
      state_q    <= 1'b0;
      press_q    <= 1'b0;
      rel_q      <= 1'b0;
      long_q     <= 1'b0;
    end else begin
      st_q       <= st_d;
      db_cnt_q   <= db_cnt_d;
      long_cnt_q <= long_cnt_d;
      state_q    <= state_d;
      press_q    <= press_d;
      rel_q      <= rel_d;
      long_q     <= long_d;
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt_q <= '0;
    end else begin
      rep_cnt_q <= rep_cnt_d;
    end
  end
`endif

  assign state_o   = state_q;
  assign press_o   = press_q;
  assign release_o = rel_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: KEY_NUM independent debounced key channels plus key_any.
// Define KEY_REPEAT_EN to enable key_long auto-repeat while a key stays held.
module key_debounce_multi import key_pkg::*; #(
  parameter int KEY_NUM       = DEF_KEY_NUM,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input logic                 clk,
  input logic                 rst_n,
  key_debounce_multi_if.slave bus
);

  if (KEY_NUM < 1 || KEY_NUM > 16) begin : g_bad_key_num
    $error("key_debounce_multi: KEY_NUM must be in 1..16");
  end

  logic [KEY_NUM-1:0] state_w;
  logic [KEY_NUM-1:0] press_w;
  logic [KEY_NUM-1:0] rel_w;
  logic [KEY_NUM-1:0] long_w;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_chan
    key_debounce_chan #(
      .DB_CYCLES     (DB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_i     (bus.key_in[i]),
      .state_o   (state_w[i]),
      .press_o   (press_w[i]),
      .release_o (rel_w[i]),
      .long_o    (long_w[i])
    );
  end

  // key_any is combinational so it lines up with the registered press pulses.
  assign bus.key_state   = state_w;
  assign bus.key_press   = press_w;
  assign bus.key_release = rel_w;
  assign bus.key_long    = long_w;
  assign bus.key_any     = |press_w;

endmodule

// File: tb/tb_key_debounce_multi.sv
// Directed bench for key_debounce_multi: DB=16, LONG=64, REPEAT=8, 4 keys, 20 ns clock.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_key_debounce_multi;
  import key_pkg::*;

  localparam int KN = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  key_debounce_multi_if #(.KEY_NUM(KN)) bus();

  key_debounce_multi #(
    .KEY_NUM       (KN),
    .DB_CYCLES     (16),
    .LONG_CYCLES   (64),
    .REPEAT_CYCLES (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.key_in = 4'hF;
    repeat (3) @(negedge clk);
    total++; if (bus.key_state !== 4'h0) begin bad++; $display("FAIL reset_state got=%h want=0", bus.key_state); end
    total++; if (bus.key_press !== 4'h0) begin bad++; $display("FAIL reset_press got=%h want=0", bus.key_press); end
    total++; if (bus.key_release !== 4'h0) begin bad++; $display("FAIL reset_release got=%h want=0", bus.key_release); end
    total++; if (bus.key_long !== 4'h0) begin bad++; $display("FAIL reset_long got=%h want=0", bus.key_long); end
    total++; if (bus.key_any !== 1'b0) begin bad++; $display("FAIL reset_any got=%b want=0", bus.key_any); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_clean_press();
    logic ep, es, er;
    bus.key_in[0] = 1'b0;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      ep = (c == 19);
      es = (c >= 19 && c < 59);
      er = (c == 59);
      total++; if (bus.key_press[0] !== ep) begin bad++; $display("FAIL clean_press c=%0d got=%b want=%b", c, bus.key_press[0], ep); end
      total++; if (bus.key_any !== ep) begin bad++; $display("FAIL clean_any c=%0d got=%b want=%b", c, bus.key_any, ep); end
      total++; if (bus.key_state[0] !== es) begin bad++; $display("FAIL clean_state c=%0d got=%b want=%b", c, bus.key_state[0], es); end
      total++; if (bus.key_release[0] !== er) begin bad++; $display("FAIL clean_release c=%0d got=%b want=%b", c, bus.key_release[0], er); end
      total++; if (bus.key_long[0] !== 1'b0) begin bad++; $display("FAIL clean_long c=%0d got=%b want=0", c, bus.key_long[0]); end
      if (c == 40) bus.key_in[0] = 1'b1;
    end
  endtask

  task automatic test_bounce();
    bus.key_in[1] = 1'b0;
    for (int c = 1; c <= 85; c++) begin
      @(negedge clk);
      total++; if (bus.key_press[1] !== 1'b0) begin bad++; $display("FAIL bounce_press c=%0d got=%b want=0", c, bus.key_press[1]); end
      total++; if (bus.key_state[1] !== 1'b0) begin bad++; $display("FAIL bounce_state c=%0d got=%b want=0", c, bus.key_state[1]); end
      total++; if (bus.key_release[1] !== 1'b0) begin bad++; $display("FAIL bounce_release c=%0d got=%b want=0", c, bus.key_release[1]); end
      total++; if (bus.key_any !== 1'b0) begin bad++; $display("FAIL bounce_any c=%0d got=%b want=0", c, bus.key_any); end
      if (c < 60 && c % 5 == 0) bus.key_in[1] = ~bus.key_in[1];
      if (c == 60) bus.key_in[1] = 1'b1;
    end
  endtask

  task automatic test_min_pulse();
    logic ep, es, er;
    bus.key_in[3] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      total++; if (bus.key_press[3] !== 1'b0) begin bad++; $display("FAIL short_press c=%0d got=%b want=0", c, bus.key_press[3]); end
      total++; if (bus.key_state[3] !== 1'b0) begin bad++; $display("FAIL short_state c=%0d got=%b want=0", c, bus.key_state[3]); end
      if (c == 15) bus.key_in[3] = 1'b1;
    end
    bus.key_in[3] = 1'b0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      ep = (c == 19);
      es = (c >= 19 && c < 36);
      er = (c == 36);
      total++; if (bus.key_press[3] !== ep) begin bad++; $display("FAIL minimum_press c=%0d got=%b want=%b", c, bus.key_press[3], ep); end
      total++; if (bus.key_state[3] !== es) begin bad++; $display("FAIL minimum_state c=%0d got=%b want=%b", c, bus.key_state[3], es); end
      total++; if (bus.key_release[3] !== er) begin bad++; $display("FAIL minimum_release c=%0d got=%b want=%b", c, bus.key_release[3], er); end
      if (c == 17) bus.key_in[3] = 1'b1;
    end
  endtask

  task automatic test_long_press();
    logic ep, es, er, el;
    bus.key_in[2] = 1'b0;
    for (int c = 1; c <= 145; c++) begin
      @(negedge clk);
      ep = (c == 19);
      es = (c >= 19 && c < 139);
      er = (c == 139);
`ifdef KEY_REPEAT_EN
      el = (c >= 83 && c <= 123 && (c - 83) % 8 == 0);
`else
      el = (c == 83);
`endif
      total++; if (bus.key_press[2] !== ep) begin bad++; $display("FAIL long_press c=%0d got=%b want=%b", c, bus.key_press[2], ep); end
      total++; if (bus.key_long[2] !== el) begin bad++; $display("FAIL long_long c=%0d got=%b want=%b", c, bus.key_long[2], el); end
      total++; if (bus.key_state[2] !== es) begin bad++; $display("FAIL long_state c=%0d got=%b want=%b", c, bus.key_state[2], es); end
      total++; if (bus.key_release[2] !== er) begin bad++; $display("FAIL long_release c=%0d got=%b want=%b", c, bus.key_release[2], er); end
      if (c == 120) bus.key_in[2] = 1'b1;
    end
  endtask

  task automatic test_release_glitch();
    logic es, er, el;
    bus.key_in[0] = 1'b0;
    for (int c = 1; c <= 125; c++) begin
      @(negedge clk);
      es = (c >= 19 && c < 119);
      er = (c == 119);
`ifdef KEY_REPEAT_EN
      el = (c >= 83 && c <= 103 && (c - 83) % 8 == 0);
`else
      el = (c == 83);
`endif
      total++; if (bus.key_state[0] !== es) begin bad++; $display("FAIL glitch_state c=%0d got=%b want=%b", c, bus.key_state[0], es); end
      total++; if (bus.key_release[0] !== er) begin bad++; $display("FAIL glitch_release c=%0d got=%b want=%b", c, bus.key_release[0], er); end
      total++; if (bus.key_long[0] !== el) begin bad++; $display("FAIL glitch_long c=%0d got=%b want=%b", c, bus.key_long[0], el); end
      if (c == 30) bus.key_in[0] = 1'b1;
      if (c == 31) bus.key_in[0] = 1'b0;
      if (c == 100) bus.key_in[0] = 1'b1;
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] ep, es, er;
    logic       ea;
    bus.key_in = 4'b0000;
    for (int c = 1; c <= 55; c++) begin
      @(negedge clk);
      ep = (c == 19) ? 4'hF : 4'h0;
      es = (c >= 19 && c < 49) ? 4'hF : 4'h0;
      er = (c == 49) ? 4'hF : 4'h0;
      ea = (c == 19);
      total++; if (bus.key_press !== ep) begin bad++; $display("FAIL simul_press c=%0d got=%h want=%h", c, bus.key_press, ep); end
      total++; if (bus.key_any !== ea) begin bad++; $display("FAIL simul_any c=%0d got=%b want=%b", c, bus.key_any, ea); end
      total++; if (bus.key_state !== es) begin bad++; $display("FAIL simul_state c=%0d got=%h want=%h", c, bus.key_state, es); end
      total++; if (bus.key_release !== er) begin bad++; $display("FAIL simul_release c=%0d got=%h want=%h", c, bus.key_release, er); end
      if (c == 30) bus.key_in = 4'hF;
    end
  endtask

  task automatic test_reset_mid();
    logic ep, es, er;
    bus.key_in[0] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      total++; if (bus.key_press[0] !== 1'b0) begin bad++; $display("FAIL midrst_pre_press c=%0d got=%b want=0", c, bus.key_press[0]); end
    end
    rst_n = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      total++; if (bus.key_state !== 4'h0) begin bad++; $display("FAIL midrst_state c=%0d got=%h want=0", c, bus.key_state); end
      total++; if (bus.key_press !== 4'h0) begin bad++; $display("FAIL midrst_press c=%0d got=%h want=0", c, bus.key_press); end
      total++; if (bus.key_any !== 1'b0) begin bad++; $display("FAIL midrst_any c=%0d got=%b want=0", c, bus.key_any); end
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      ep = (c == 19);
      es = (c >= 19 && c < 44);
      er = (c == 44);
      total++; if (bus.key_press[0] !== ep) begin bad++; $display("FAIL midrst_after_press c=%0d got=%b want=%b", c, bus.key_press[0], ep); end
      total++; if (bus.key_state[0] !== es) begin bad++; $display("FAIL midrst_after_state c=%0d got=%b want=%b", c, bus.key_state[0], es); end
      total++; if (bus.key_release[0] !== er) begin bad++; $display("FAIL midrst_after_release c=%0d got=%b want=%b", c, bus.key_release[0], er); end
      if (c == 25) bus.key_in[0] = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_min_pulse();
    test_long_press();
    test_release_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
